// File: rtl/sha256_sequencer.sv
// Control sequencer for an external SHA-256 core: walks a padded message
// chunk by chunk through the core's load/expand/round phases and captures the digest.
module sha256_sequencer #(
  parameter int CHUNK_CNT_W = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [CHUNK_CNT_W-1:0] num_chunks,
  input  logic [511:0]           chunk_in,
  input  logic                   chunk_valid,
  output logic                   chunk_ready,
  output logic                   busy,
  output logic [255:0]           hash_out,
  output logic                   hash_valid,
  output logic                   core_reset_n,
  output logic [2:0]             core_state,
  output logic                   core_flag,
  output logic [511:0]           core_chunk,
  input  logic [255:0]           core_hash
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_WAIT,
    S_LOAD,
    S_EXPAND,
    S_ROUND,
    S_FINAL,
    S_DONE
  } state_t;

  localparam logic [6:0] EXPAND_LAST = 7'd47;
  localparam logic [6:0] ROUND_LAST  = 7'd63;
  localparam logic [CHUNK_CNT_W-1:0] ONE_CHUNK = CHUNK_CNT_W'(1);

  state_t                 state, state_nxt;
  logic [6:0]             cyc, cyc_nxt;
  logic [CHUNK_CNT_W-1:0] remaining, remaining_nxt;

  // LOAD and EXPAND share code 3 on the core bus; core_flag tells them apart.
  function automatic logic [2:0] core_code(input state_t s);
    case (s)
      S_IDLE:   core_code = 3'd0;
      S_INIT:   core_code = 3'd1;
      S_WAIT:   core_code = 3'd2;
      S_LOAD:   core_code = 3'd3;
      S_EXPAND: core_code = 3'd3;
      S_ROUND:  core_code = 3'd4;
      S_FINAL:  core_code = 3'd5;
      S_DONE:   core_code = 3'd6;
      default:  core_code = 3'd0;
    endcase
  endfunction

  assign core_reset_n = ~reset;

  always_comb begin
    // NOTE: every output of this block is given a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_nxt     = state;
    cyc_nxt       = cyc;
    remaining_nxt = remaining;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt     = S_INIT;
          remaining_nxt = (num_chunks == '0) ? ONE_CHUNK : num_chunks;
        end
      end
      S_INIT: state_nxt = S_WAIT;
      S_WAIT: begin
        if (chunk_valid) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        state_nxt = S_EXPAND;
        cyc_nxt   = '0;
      end
      S_EXPAND: begin
        if (cyc == EXPAND_LAST) begin
          state_nxt = S_ROUND;
          cyc_nxt   = '0;
        end else begin
          cyc_nxt = cyc + 7'd1;
        end
      end
      S_ROUND: begin
        if (cyc == ROUND_LAST) begin
          cyc_nxt = '0;
          // Later chunks skip INIT so the core keeps its chaining value.
          if (remaining > ONE_CHUNK) begin
            remaining_nxt = remaining - ONE_CHUNK;
            state_nxt     = S_WAIT;
          end else begin
            state_nxt = S_FINAL;
          end
        end else begin
          cyc_nxt = cyc + 7'd1;
        end
      end
      S_FINAL: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Core-facing outputs are registered from the next state so they line up
  // exactly with the state register.
  always_ff @(posedge clock) begin
    // NOTE: state uses non-blocking assignments so every register here
    // samples pre-edge values, independent of statement order.
    if (reset) begin
      state       <= S_IDLE;
      cyc         <= '0;
      remaining   <= '0;
      core_state  <= 3'd0;
      core_flag   <= 1'b0;
      chunk_ready <= 1'b0;
      busy        <= 1'b0;
      hash_valid  <= 1'b0;
      hash_out    <= '0;
      core_chunk  <= '0;
    end else begin
      state       <= state_nxt;
      cyc         <= cyc_nxt;
      remaining   <= remaining_nxt;
      core_state  <= core_code(state_nxt);
      core_flag   <= (state_nxt == S_EXPAND);
      chunk_ready <= (state_nxt == S_WAIT);
      busy        <= (state_nxt != S_IDLE);
      hash_valid  <= (state == S_DONE);
      if (state == S_DONE) hash_out <= core_hash;
      if ((state == S_WAIT) && chunk_valid) core_chunk <= chunk_in;
    end
  end

endmodule

// File: tb/tb_sha256_sequencer.sv
// Scoreboard bench for sha256_sequencer with a behavioural SHA-256 core attached;
// expected digests come from known vectors or a whole-message reference hash.
module tb_sha256_sequencer;

  localparam int CW = 8;

  localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] ABC_DIGEST = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] TWO_DIGEST = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [511:0] ABC_CHUNK  = {32'h61626380, 448'd0, 32'h00000018};

  typedef struct {
    logic [255:0] digest;
    int           cyc;
    string        name;
  } exp_t;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [CW-1:0]  num_chunks = '0;
  logic [511:0]   chunk_in = '0;
  logic           chunk_valid = 1'b0;
  logic           chunk_ready, busy, hash_valid, core_reset_n, core_flag;
  logic [255:0]   hash_out, core_hash;
  logic [2:0]     core_state;
  logic [511:0]   core_chunk;

  logic [255:0]   core_h = '0;
  logic [255:0]   last_hash = '0;
  logic [511:0]   msg [256];
  exp_t           exp_q [$];
  int             checks = 0;
  int             errors = 0;
  int             cyc = 0;

  sha256_sequencer #(.CHUNK_CNT_W(CW)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .num_chunks   (num_chunks),
    .chunk_in     (chunk_in),
    .chunk_valid  (chunk_valid),
    .chunk_ready  (chunk_ready),
    .busy         (busy),
    .hash_out     (hash_out),
    .hash_valid   (hash_valid),
    .core_reset_n (core_reset_n),
    .core_state   (core_state),
    .core_flag    (core_flag),
    .core_chunk   (core_chunk),
    .core_hash    (core_hash)
  );

  assign core_hash = core_h;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] va, vb, vc, vd, ve, vf, vg, vh, t1, t2, s0, s1;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    {va, vb, vc, vd, ve, vf, vg, vh} = hin;
    for (int t = 0; t < 64; t++) begin
      s1 = rotr(ve, 6) ^ rotr(ve, 11) ^ rotr(ve, 25);
      t1 = vh + s1 + ((ve & vf) ^ (~ve & vg)) + K[t] + w[t];
      s0 = rotr(va, 2) ^ rotr(va, 13) ^ rotr(va, 22);
      t2 = s0 + ((va & vb) ^ (va & vc) ^ (vb & vc));
      vh = vg; vg = vf; vf = ve; ve = vd + t1;
      vd = vc; vc = vb; vb = va; va = t1 + t2;
    end
    return {hin[255:224] + va, hin[223:192] + vb, hin[191:160] + vc, hin[159:128] + vd,
            hin[127:96]  + ve, hin[95:64]   + vf, hin[63:32]   + vg, hin[31:0]    + vh};
  endfunction

  function automatic logic [255:0] digest_of(input int n);
    logic [255:0] h;
    h = IV;
    for (int i = 0; i < n; i++) h = compress(h, msg[i]);
    return h;
  endfunction

  function automatic logic [511:0] rand_chunk();
    logic [511:0] c;
    for (int w = 0; w < 16; w++) c[w*32 +: 32] = $urandom;
    return c;
  endfunction

  // Behavioural core: IV on INIT, one whole compression per LOAD.
  initial begin : core_model
    forever begin
      @(negedge clock);
      if (!core_reset_n)                        core_h = '0;
      else if (core_state == 3'd1)              core_h = IV;
      else if (core_state == 3'd3 && !core_flag) core_h = compress(core_h, core_chunk);
    end
  end

  initial begin : monitor
    exp_t m;
    int   exp_len;
    int   rnd_len;
    exp_len = 0;
    rnd_len = 0;
    forever begin
      @(negedge clock);
      check("core_reset_n", 256'(core_reset_n), 256'(!reset));
      check("busy vs core_state", 256'(busy), 256'(core_state != 3'd0));
      check("chunk_ready vs core_state", 256'(chunk_ready), 256'(core_state == 3'd2));
      check("core_state range", 256'(core_state <= 3'd6), 256'(1));
      if (core_state != 3'd3) check("core_flag outside state 3", 256'(core_flag), 256'(0));
      if (core_state == 3'd3 && core_flag) exp_len++;
      else begin
        if (exp_len != 0 && !reset) check("EXPAND length", 256'(exp_len), 256'(48));
        exp_len = 0;
      end
      if (core_state == 3'd4) rnd_len++;
      else begin
        if (rnd_len != 0 && !reset) check("ROUND length", 256'(rnd_len), 256'(64));
        rnd_len = 0;
      end
      if (reset) last_hash = '0;
      if (hash_valid) begin
        check("hash_valid has pending expectation", 256'(exp_q.size() != 0), 256'(1));
        if (exp_q.size() != 0) begin
          m = exp_q.pop_front();
          check({m.name, " digest"}, hash_out, m.digest);
          check({m.name, " hash_valid cycle"}, 256'(cyc), 256'(m.cyc));
        end
        last_hash = hash_out;
      end else begin
        check("hash_out hold", hash_out, last_hash);
      end
    end
  end

  // Starts a message in the current cycle; stall = extra WAIT_CHUNK cycles per chunk.
  task automatic run_msg(input string name, input int n, input logic [CW-1:0] nfield,
                         input int stall, input bit poke, input bit use_const,
                         input logic [255:0] const_digest);
    exp_t e;
    int   waited;
    e.name   = name;
    e.digest = use_const ? const_digest : digest_of(n);
    e.cyc    = cyc + 118 + 114 * (n - 1) + stall * n;
    exp_q.push_back(e);
    start       = 1'b1;
    num_chunks  = nfield;
    chunk_in    = msg[0];
    chunk_valid = (stall == 0);
    @(posedge clock); #1;
    start      = 1'b0;
    num_chunks = CW'($urandom);
    for (int i = 0; i < n; i++) begin
      chunk_in    = msg[i];
      chunk_valid = (stall == 0);
      waited = 0;
      do begin
        @(negedge clock);
        waited++;
      end while (!chunk_ready && waited < 400);
      check({name, " chunk_ready seen"}, 256'(chunk_ready), 256'(1));
      if (!chunk_ready) break;
      for (int s = 0; s < stall; s++) begin
        check({name, " stalled core_state"}, 256'(core_state), 256'(2));
        check({name, " stalled chunk_ready"}, 256'(chunk_ready), 256'(1));
        @(negedge clock);
      end
      chunk_valid = 1'b1;
      @(posedge clock); #1;
      if (poke && i == 0) begin
        repeat (10) @(negedge clock);
        check({name, " in EXPAND at poke"}, 256'({core_state, core_flag}), 256'({3'd3, 1'b1}));
        #1;
        start      = 1'b1;
        num_chunks = CW'(5);
        @(posedge clock); #1;
        start = 1'b0;
      end
    end
    chunk_in    = rand_chunk();
    chunk_valid = (stall == 0);
    waited = 0;
    while (exp_q.size() != 0 && waited < 300) begin
      @(negedge clock); #1;
      waited++;
    end
    check({name, " completed"}, 256'(exp_q.size()), 256'(0));
    exp_q.delete();
    chunk_valid = 1'b0;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : driver
    int waited;
    repeat (3) @(posedge clock); #1;
    check("reset core_state", 256'(core_state), 256'(0));
    check("reset core_flag", 256'(core_flag), 256'(0));
    check("reset chunk_ready", 256'(chunk_ready), 256'(0));
    check("reset busy", 256'(busy), 256'(0));
    check("reset hash_valid", 256'(hash_valid), 256'(0));
    check("reset hash_out", hash_out, 256'(0));
    check("reset core_chunk zero", 256'(core_chunk == '0), 256'(1));
    check("reset core_reset_n", 256'(core_reset_n), 256'(0));
    reset = 1'b0;

    msg[0] = ABC_CHUNK;
    run_msg("abc", 1, CW'(1), 0, 1'b0, 1'b1, ABC_DIGEST);

    msg[0] = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
              32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
              32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
              32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    msg[1] = {480'd0, 32'h000001c0};
    run_msg("two-chunk", 2, CW'(2), 0, 1'b0, 1'b1, TWO_DIGEST);

    msg[0] = ABC_CHUNK;
    run_msg("abc stall 20", 1, CW'(1), 20, 1'b0, 1'b1, ABC_DIGEST);
    run_msg("abc start while busy", 1, CW'(1), 0, 1'b1, 1'b1, ABC_DIGEST);
    run_msg("abc num_chunks 0", 1, CW'(0), 0, 1'b0, 1'b1, ABC_DIGEST);

    // Abort a three-chunk message in ROUND cycle 30.
    start       = 1'b1;
    num_chunks  = CW'(3);
    chunk_in    = msg[0];
    chunk_valid = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    waited = 0;
    do begin
      @(negedge clock);
      waited++;
    end while (core_state != 3'd4 && waited < 400);
    check("abort run reached ROUND", 256'(core_state), 256'(4));
    repeat (30) @(negedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check("abort core_state", 256'(core_state), 256'(0));
    check("abort busy", 256'(busy), 256'(0));
    check("abort core_flag", 256'(core_flag), 256'(0));
    check("abort hash_valid", 256'(hash_valid), 256'(0));
    check("abort core_chunk zero", 256'(core_chunk == '0), 256'(1));
    check("abort hash_out", hash_out, 256'(0));
    @(negedge clock); #1;
    reset       = 1'b0;
    chunk_valid = 1'b0;
    run_msg("abc after reset", 1, CW'(1), 0, 1'b0, 1'b1, ABC_DIGEST);

    for (int r = 0; r < 10; r++) begin
      int            n;
      int            stall;
      logic [CW-1:0] nf;
      bit            poke;
      n     = $urandom_range(1, 4);
      nf    = (n == 1 && $urandom_range(0, 1) == 1) ? CW'(0) : CW'(n);
      stall = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 5);
      poke  = ($urandom_range(0, 1) == 1);
      for (int i = 0; i < n; i++) msg[i] = rand_chunk();
      repeat ($urandom_range(0, 3)) @(posedge clock);
      #1;
      run_msg($sformatf("random run %0d", r), n, nf, stall, poke, 1'b0, '0);
    end

    for (int i = 0; i < 255; i++) msg[i] = rand_chunk();
    run_msg("max chunk count", 255, CW'(255), 0, 1'b0, 1'b0, '0);

    repeat (5) @(negedge clock);
    check("no leftover expectations", 256'(exp_q.size()), 256'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha256_sequencer.md
SHA256_SEQUENCER -- requirements
Module: sha256_sequencer

Interface
REQ-001 Parameter: CHUNK_CNT_W, default 8, width of the chunk-count input.
REQ-002 clock  input  1  single clock; all logic rising-edge.
REQ-003 reset  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request to hash a new message; sampled only in IDLE.
REQ-005 num_chunks  input  CHUNK_CNT_W  number of 512-bit chunks in the message, sampled with start.
REQ-006 chunk_in  input  512  next pre-padded chunk, bit 511 = first message bit.
REQ-007 chunk_valid  input  1  chunk_in is valid.
REQ-008 chunk_ready  output  1  sequencer accepts chunk_in this cycle.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 hash_out  output  256  final digest, {h0..h7}.
REQ-011 hash_valid  output  1  one-cycle pulse when hash_out is updated.
REQ-012 core_reset_n  output  1  core reset, active-low, equal to ~reset (combinational).
REQ-013 core_state  output  3  state code driven to the SHA-256 core.
REQ-014 core_flag  output  1  core load/expand select in state 3.
REQ-015 core_chunk  output  512  registered chunk driven to the core.
REQ-016 core_hash  input  256  HASH output of the core.

Function
REQ-017 FSM states, with the core_state code driven in each: IDLE=0, INIT=1, WAIT_CHUNK=2, LOAD=3 with core_flag=0, EXPAND=3 with core_flag=1, ROUND=4, FINAL=5, DONE=6.
REQ-018 core_flag SHALL be 0 in every state except EXPAND.
REQ-019 IDLE: on start=1, latch num_chunks into the remaining counter (0 treated as 1), then go to INIT; otherwise stay in IDLE.
REQ-020 start SHALL be ignored when not in IDLE; there is no queuing.
REQ-021 INIT: one cycle, then go to WAIT_CHUNK.
REQ-022 WAIT_CHUNK: chunk_ready=1. On chunk_valid, register chunk_in into core_chunk and go to LOAD. Otherwise stay, for unbounded time.
REQ-023 chunk_ready SHALL be 0 in every other state; core_chunk SHALL only change on a WAIT_CHUNK handshake.
REQ-024 LOAD: one cycle, then go to EXPAND.
REQ-025 EXPAND: exactly 48 cycles, counted by a 7-bit cycle counter cleared on entry, then go to ROUND.
REQ-026 ROUND: exactly 64 cycles, with the same counter cleared on entry.
- If remaining>1 at exit: decrement remaining and go to WAIT_CHUNK; INIT is not revisited, so chaining values carry over.
- If remaining==1: go to FINAL.
REQ-027 FINAL: one cycle, then go to DONE.
REQ-028 DONE: register core_hash into hash_out, set hash_valid=1 for the next cycle only, then go to IDLE.
REQ-029 Cycle count: with start at cycle 0 and chunk_valid held high, hash_valid SHALL be high in cycle 118. Each additional chunk adds 114 cycles, plus any WAIT_CHUNK stall beyond 1 cycle.
REQ-030 A start in the same cycle as hash_valid is accepted, since the FSM is in IDLE then.
REQ-031 hash_out SHALL hold its value until the next DONE.
REQ-032 Remaining-counter arithmetic is unsigned CHUNK_CNT_W bits; it never underflows because the minimum is 1.
REQ-033 num_chunks = 2^CHUNK_CNT_W-1 SHALL complete without counter wrap.

Reset
REQ-034 While reset=1 at a rising edge, the next state SHALL be IDLE, from any state including mid-EXPAND or mid-ROUND.
REQ-035 Reset values: core_state=0, core_flag=0, chunk_ready=0, busy=0, hash_valid=0, hash_out=0, core_chunk=0, counters=0.
REQ-036 core_reset_n SHALL be 0 for the whole time reset=1.
REQ-037 After reset deasserts, the first start SHALL produce a correct digest; there is no residue from an aborted message.

Verification
REQ-038 Single chunk "abc" (61626380, then zeros, last word 00000018), num_chunks=1, chunk_valid held high -> hash_valid in cycle 118 with hash_out=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
REQ-039 Two-chunk "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", num_chunks=2 -> hash_out=248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1, with hash_valid in cycle 232.
REQ-040 Stall: withhold chunk_valid for 20 cycles in WAIT_CHUNK -> core_state stays 2 and chunk_ready stays 1; hash_valid arrives 20 cycles later than the unstalled case, with an identical digest.
REQ-041 start pulsed while busy (in EXPAND) -> ignored; a single hash_valid pulse results and the digest is unchanged.
REQ-042 reset asserted in ROUND cycle 30 -> next cycle core_state=0 and busy=0; a fresh "abc" run then gives the REQ-038 digest.
REQ-043 num_chunks=0 with the "abc" chunk -> behaves exactly as num_chunks=1, giving the REQ-038 digest.
